// File: rtl/dct_transpose_buffer_pkg.sv
// dct_transpose_buffer_pkg: shared constants and types for the 8x8 DCT transpose buffer.
// Contents: DCT_N (block dimension), DCT_PTR_W (row/column pointer width),
// DCT_DATA_W (sample width), ptr_t (row/column index type).
// Optional feature macro used by the design: DCT_TP_BLKCNT_EN.
package dct_transpose_buffer_pkg;
    localparam int DCT_N      = 8;
    localparam int DCT_PTR_W  = 3;
    localparam int DCT_DATA_W = 16;
    typedef logic [DCT_PTR_W-1:0] ptr_t;
endpackage

// File: rtl/dct_transpose_buffer_if.sv
// dct_transpose_buffer_if: row-in / column-out handshake bundle of the transpose buffer.
// Signals: in_valid/in_ready/in_d[8] (row from the row kernel),
// out_valid/out_ready/out_d[8]/out_last (column to the column kernel).
// Modports: slave (buffer side), master (producer/consumer side).
interface dct_transpose_buffer_if
    import dct_transpose_buffer_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_d [DCT_N];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_d [DCT_N];
    logic                     out_last;

    modport slave (
        input  in_valid, in_d, out_ready,
        output in_ready, out_valid, out_d, out_last
    );

    modport master (
        output in_valid, in_d, out_ready,
        input  in_ready, out_valid, out_d, out_last
    );
endinterface

// File: rtl/dct_tp_bank.sv
// dct_tp_bank: one 8x8 sample register array, written a row at a time, read a column at a time.
// Ports: Clk (clock), we (row write enable), wr_row (row index), wr_data[8] (row samples),
// rd_col (column index), rd_data[8] (column samples, rd_data[k] = element of row k).
// Contents are intentionally not reset.
module dct_tp_bank
    import dct_transpose_buffer_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W
) (
    input  logic                     Clk,
    input  logic                     we,
    input  ptr_t                     wr_row,
    input  logic signed [DATA_W-1:0] wr_data [DCT_N],
    input  ptr_t                     rd_col,
    output logic signed [DATA_W-1:0] rd_data [DCT_N]
);
    logic signed [DATA_W-1:0] mem [DCT_N][DCT_N];

    always_ff @(posedge Clk) begin
        if (we)
            for (int k = 0; k < DCT_N; k++)
                mem[wr_row][k] <= wr_data[k];
    end

    always_comb begin
        for (int k = 0; k < DCT_N; k++)
            rd_data[k] = mem[k][rd_col];
    end
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 transpose memory between row-pass and column-pass DCT kernels.
// Ports: Clk, Rst (sync, active-high), bus (dct_transpose_buffer_if.slave: rows in, columns out),
// blk_cnt (16-bit count of fully drained blocks, only when DCT_TP_BLKCNT_EN is defined).
// One bank fills while the other drains; full[] flags hand banks between the two sides.
module dct_transpose_buffer
    import dct_transpose_buffer_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W
) (
    input  logic Clk,
    input  logic Rst,
    dct_transpose_buffer_if.slave bus
`ifdef DCT_TP_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);
    localparam ptr_t LAST = ptr_t'(DCT_N - 1);

    logic [1:0] full, full_next;
    logic       wr_bank, rd_bank;
    ptr_t       wr_row, rd_col;
    logic       accept, xfer, fill_done, drain_done;

    logic signed [DATA_W-1:0] row [DCT_N];
    logic signed [DATA_W-1:0] rd0 [DCT_N];
    logic signed [DATA_W-1:0] rd1 [DCT_N];

    assign bus.in_ready  = ~full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_last  = bus.out_valid & (rd_col == LAST);
    assign accept        = bus.in_valid & bus.in_ready;
    assign xfer          = bus.out_valid & bus.out_ready;
    assign fill_done     = accept & (wr_row == LAST);
    assign drain_done    = xfer & (rd_col == LAST);

    for (genvar k = 0; k < DCT_N; k++) begin : g_lane
        assign row[k]       = bus.in_d[k];
        assign bus.out_d[k] = bus.out_valid ? (rd_bank ? rd1[k] : rd0[k]) : '0;
    end

    dct_tp_bank #(.DATA_W(DATA_W)) u_bank0 (
        .Clk     (Clk),
        .we      (accept & ~wr_bank),
        .wr_row  (wr_row),
        .wr_data (row),
        .rd_col  (rd_col),
        .rd_data (rd0)
    );

    dct_tp_bank #(.DATA_W(DATA_W)) u_bank1 (
        .Clk     (Clk),
        .we      (accept & wr_bank),
        .wr_row  (wr_row),
        .wr_data (row),
        .rd_col  (rd_col),
        .rd_data (rd1)
    );

    // Fill and drain completion always target different banks (one is empty,
    // the other full), so both updates can be applied independently.
    always_comb begin
        full_next = full;
        if (fill_done)
            full_next[wr_bank] = 1'b1;
        if (drain_done)
            full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_next;
            if (accept)
                wr_row <= wr_row + ptr_t'(1);
            if (fill_done)
                wr_bank <= ~wr_bank;
            if (xfer)
                rd_col <= rd_col + ptr_t'(1);
            if (drain_done)
                rd_bank <= ~rd_bank;
        end
    end

`ifdef DCT_TP_BLKCNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)
            blk_cnt <= '0;
        else if (drain_done)
            blk_cnt <= blk_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer: self-checking bench for dct_transpose_buffer.
// A table drives the identity block; hand sequences cover streaming, backpressure,
// held-off input and reset mid-fill; a random phase is checked against a block-queue model.
// Optional feature macro exercised when defined: DCT_TP_BLKCNT_EN.
module tb_dct_transpose_buffer;
    import dct_transpose_buffer_pkg::*;

    typedef struct {
        logic signed [15:0] m [8][8];
    } blk_s;

    typedef struct {
        bit          vin;
        bit          rdy;
        int          row;
        bit          ir;
        bit          ov;
        bit          ol;
        logic [15:0] o0;
        logic [15:0] o7;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dct_transpose_buffer_if bus ();

`ifdef DCT_TP_BLKCNT_EN
    logic [15:0] blk_cnt;
    dct_transpose_buffer dut (.Clk(Clk), .Rst(Rst), .bus(bus), .blk_cnt(blk_cnt));
`else
    dct_transpose_buffer dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`endif

    always #5 Clk = ~Clk;

    // Reference model: completed blocks waiting to be read, in order, plus the block being filled.
    blk_s q [$];
    blk_s cur;
    int   cur_rows = 0;
    int   rd_c = 0;
    int   drained = 0;
    vec_t tbl [16];

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, bit r, logic signed [15:0] d [8]);
        bus.in_valid  = v;
        bus.out_ready = r;
        for (int k = 0; k < 8; k++) bus.in_d[k] = d[k];
    endtask

    task automatic check_model();
        bit ov;
        ov = q.size() > 0;
        chk("in_ready", 16'(bus.in_ready), 16'(q.size() < 2));
        chk("out_valid", 16'(bus.out_valid), 16'(ov));
        chk("out_last", 16'(bus.out_last), 16'(ov && rd_c == 7));
        for (int k = 0; k < 8; k++)
            chk($sformatf("out_%0d", k), bus.out_d[k], ov ? q[0].m[k][rd_c] : 16'sd0);
`ifdef DCT_TP_BLKCNT_EN
        chk("blk_cnt", blk_cnt, 16'(drained));
`endif
    endtask

    task automatic tick();
        bit acc, xf;
        acc = bus.in_valid && q.size() < 2;
        xf  = bus.out_ready && q.size() > 0;
        @(posedge Clk);
        if (Rst) begin
            q.delete();
            cur_rows = 0;
            rd_c = 0;
            drained = 0;
        end else begin
            if (xf) begin
                rd_c++;
                if (rd_c == 8) begin
                    void'(q.pop_front());
                    rd_c = 0;
                    drained++;
                end
            end
            if (acc) begin
                for (int k = 0; k < 8; k++) cur.m[cur_rows][k] = bus.in_d[k];
                cur_rows++;
                if (cur_rows == 8) begin
                    q.push_back(cur);
                    cur_rows = 0;
                end
            end
        end
        #1;
    endtask

    task automatic step(bit v, bit r, logic signed [15:0] d [8]);
        drive(v, r, d);
        #4;
        check_model();
        tick();
    endtask

    initial begin
        logic signed [15:0] d [8];
        for (int k = 0; k < 8; k++) d[k] = '0;
        drive(0, 0, d);
        tick();
        tick();
        Rst = 1'b0;
        #4;
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check_model();
        tick();

        // Identity block from a table: rows 8r+k, then 8 drain cycles.
        for (int i = 0; i < 16; i++) begin
            tbl[i].vin = i < 8;
            tbl[i].rdy = 1'b1;
            tbl[i].row = i;
            tbl[i].ir  = 1'b1;
            tbl[i].ov  = i >= 8;
            tbl[i].ol  = i == 15;
            tbl[i].o0  = i >= 8 ? 16'(i - 8) : 16'd0;
            tbl[i].o7  = i >= 8 ? 16'(56 + i - 8) : 16'd0;
        end
        foreach (tbl[i]) begin
            for (int k = 0; k < 8; k++) d[k] = 16'(8 * tbl[i].row + k);
            drive(tbl[i].vin, tbl[i].rdy, d);
            #4;
            chk($sformatf("tbl%0d_in_ready", i), 16'(bus.in_ready), 16'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 16'(bus.out_valid), 16'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_last", i), 16'(bus.out_last), 16'(tbl[i].ol));
            chk($sformatf("tbl%0d_out_0", i), bus.out_d[0], tbl[i].o0);
            chk($sformatf("tbl%0d_out_7", i), bus.out_d[7], tbl[i].o7);
            check_model();
            tick();
        end

        // Back-to-back streaming: 4 blocks, out_ready held high.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            step(i < 32, 1, d);
        end

        // Backpressure: load 2 blocks with out_ready low, then present 0x7FFF while stalled.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            step(1, 0, d);
        end
        for (int k = 0; k < 8; k++) d[k] = 16'sh7FFF;
        for (int i = 0; i < 5; i++) begin
            #0;
            step(1, 0, d);
        end
        chk("stall_in_ready", 16'(bus.in_ready), 16'd0);
        for (int i = 0; i < 8; i++) step(0, 1, d);
        #4;
        chk("release_in_ready", 16'(bus.in_ready), 16'd1);
        check_model();
        tick();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            step(i < 8, 1, d);
        end

        // Reset mid-fill, then a negative-valued block.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            step(1, 1, d);
        end
        Rst = 1'b1;
        drive(0, 1, d);
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < 8; k++) d[k] = -16'(8 * i + k);
            step(i < 8, 1, d);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, d);
        end
        for (int i = 0; i < 20; i++) step(0, 1, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
Ping-pong 8x8 transpose memory between the row-pass and column-pass 1-D DCT kernels of the 2-D DCT.
- Accepts one 8-sample row per cycle from the row kernel outputs.
- After a full block, emits the block column-wise, one 8-sample column per cycle, to the column kernel.
- Two banks allow filling one block while draining the previous one.

Parameters:
DATA_W, 16, width of each signed sample (matches the `OUTPUTWIDTH define)
N, 8, block dimension; fixed at 8 (pointer widths are 3 bits)

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  synchronous reset, active-high
in_valid  in  1  row present on in_0..in_7
in_ready  out  1  buffer can accept a row this cycle
in_0..in_7  in  DATA_W each, signed  row samples, in_k = element k of the row
out_valid  out  1  column present on out_0..out_7
out_ready  in  1  downstream accepts the column this cycle
out_0..out_7  out  DATA_W each, signed  column samples, out_k = element from row k
out_last  out  1  high with the 8th (final) column of a block
blk_cnt  out  16  blocks fully drained; present only with DCT_TP_BLKCNT_EN

Behaviour:
- State:
  - two banks of 8x8 DATA_W registers;
  - full[1:0] flags;
  - wr_bank (1b), wr_row (3b);
  - rd_bank (1b), rd_col (3b).
- Reset (Rst=1 at edge):
  - full=0, wr_bank=rd_bank=0, wr_row=rd_col=0;
  - in_ready=1 after reset; out_valid=0, out_last=0, out_k=0, blk_cnt=0.
  - Bank contents are not reset.
- Reset mid-operation: any partially written or partially drained block is discarded; nothing is emitted afterwards.
- Write side:
  - in_ready = ~full[wr_bank], combinational from flops.
  - Row accept = in_valid & in_ready. On accept, bank[wr_bank][wr_row][k] <= in_k and wr_row increments.
  - On the accept with wr_row==7: full[wr_bank]<=1, wr_bank toggles, wr_row<=0.
  - in_valid while in_ready=0 is ignored, with no side effects; upstream holds its data.
- Read side:
  - out_valid = full[rd_bank].
  - out_k = bank[rd_bank][k][rd_col] when out_valid=1, else 0.
  - out_last = out_valid & (rd_col==7).
  - Column transfer = out_valid & out_ready. On transfer, rd_col increments.
  - On the transfer with rd_col==7: full[rd_bank]<=0, rd_bank toggles, rd_col<=0.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Fill-complete and drain-complete in the same cycle touch different banks; both flag updates take effect.
  - A bank that is freed becomes writable on the next cycle. There is no same-cycle bypass.
- Latency and throughput:
  - The first column of a block is valid on the cycle after its 8th row is accepted.
  - With out_ready held at 1, 1 row/cycle in and 1 column/cycle out are sustained indefinitely, and in_ready never drops.
- Stall: when both banks are full, in_ready=0 until the read bank finishes draining.
- No arithmetic: samples pass bit-exact; no width change.

Optional Feature:
DCT_TP_BLKCNT_EN
- Defined:
  - adds the 16-bit blk_cnt output;
  - blk_cnt increments on each drain-complete transfer and wraps 0xFFFF->0;
  - reset to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package / define.v: DCT_N=8, DCT_PTR_W=3, sample width define, DCT_TP_BLKCNT_EN.
- One natural sub-module, dct_tp_bank, instantiated twice:
  - one 8x8 register array;
  - row write port (we, row index, 8 samples);
  - column read port (column index, 8 samples).
- The top level holds pointers, flags, handshake logic and the bank select mux.

Test Plan:
- Identity block: rows r=0..7 with in_k=8r+k, out_ready=1 → columns c=0..7 give out_k=8k+c, out_last only at c=7, and the first out_valid comes one cycle after the 8th row.
- Back-to-back streaming: 4 blocks of contiguous rows, out_ready=1 → in_ready stays 1 throughout, 32 columns out, each block transposed correctly.
- Backpressure: out_ready=0 after 2 blocks are loaded → in_ready=0 on the next cycle, and out_0..7 hold column 0 of block 0. Releasing out_ready gives in_ready=1 one cycle after block 0's last column.
- Held-off input: in_valid=1 while in_ready=0 with value 0x7FFF → never appears in the output; the subsequent block is unaffected.
- Reset mid-fill: Rst after 5 rows, then a fresh 8-row block with in_k=-(8r+k) → only the fresh block is emitted, correctly transposed, with negatives sign-preserved.
- With DCT_TP_BLKCNT_EN: drain 3 blocks → blk_cnt=3. Force 65536 drains → wraps to 0.
